iob_vga_timing: RTL and testbench

- Raster timing generator; sits directly upstream of the pseudo-memory pixel renderer.
- Drives the current pixel coordinates (pixel_x, pixel_y) into the renderer, samples the 12-bit colour it returns, and drives the board VGA pins (4:4:4 RGB, HSYNC, VSYNC).
- Also provides a frame-start pulse and a vertical-blank flag so software can update object positions outside the visible region.

---
 rtl/iob_vga_timing.sv | 155 +++++++++++++++
 tb/tb_iob_vga_timing.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_vga_timing.sv
// iob_vga_timing
// --------------
// Raster timing generator for a VGA output. It walks a pixel/line raster,
// presents the current coordinate to the downstream renderer, samples the
// colour the renderer returns, and drives the board VGA pins with colour and
// syncs aligned to each other.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   en           1 = run, 0 = hold counters at zero and blank the pins
//   rgb_in       colour for (pixel_x, pixel_y), {R[11:8], G[7:4], B[3:0]}
//   pixel_x      current horizontal counter
//   pixel_y      current vertical counter
//   vga_r/g/b    4-bit colour pins
//   vga_hs       horizontal sync pin
//   vga_vs       vertical sync pin
//   vblank       1 while pixel_y is below the visible area
//   frame_start  one-clock pulse when the raster returns to (0,0)
module iob_vga_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // All comparison constants are pre-sized to the counter widths.
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [3:0]  divCnt_q, divCnt_d;
  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        frameStart_q, frameStart_d;

  logic tick;
  logic hLast;
  logic vLast;
  logic vis;
  logic hsActive;
  logic vsActive;

  // One tick per pixel period; with CLK_DIV=1 the divider stays at zero and
  // every enabled clock is a tick.
  assign tick     = (divCnt_q == DIV_LAST) && en;
  assign hLast    = (hCnt_q == H_LAST);
  assign vLast    = (vCnt_q == V_LAST);
  assign vis      = (hCnt_q < H_VIS_C) && (vCnt_q < V_VIS_C);
  assign hsActive = (hCnt_q >= HS_BEG) && (hCnt_q < HS_END);
  assign vsActive = (vCnt_q >= VS_BEG) && (vCnt_q < VS_END);

  // Next-state logic for the raster counters and the output stage. The pins
  // are loaded from the pre-increment coordinate on each tick, which gives
  // colour and syncs the same one-pixel latency. Dropping en restarts the
  // raster at (0,0) and blanks the pins, exactly like a reset.
  always_comb begin
    divCnt_d     = divCnt_q;
    hCnt_d       = hCnt_q;
    vCnt_d       = vCnt_q;
    rgb_d        = rgb_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    frameStart_d = 1'b0;

    if (!en) begin
      divCnt_d = '0;
      hCnt_d   = '0;
      vCnt_d   = '0;
      rgb_d    = '0;
      hs_d     = ~SYNC_POL;
      vs_d     = ~SYNC_POL;
    end else if (tick) begin
      divCnt_d = '0;
      if (hLast) begin
        hCnt_d = '0;
        vCnt_d = vLast ? 10'd0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
      rgb_d        = vis ? rgb_in : 12'd0;
      hs_d         = hsActive ? SYNC_POL : ~SYNC_POL;
      vs_d         = vsActive ? SYNC_POL : ~SYNC_POL;
      // Pulses only on a genuine wrap of the last pixel of the last line,
      // so enabling or resetting never produces a frame_start.
      frameStart_d = hLast && vLast;
    end else begin
      divCnt_d = divCnt_q + 4'd1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      divCnt_q     <= '0;
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      rgb_q        <= '0;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      frameStart_q <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign pixel_x     = hCnt_q;
  assign pixel_y     = vCnt_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vblank      = (vCnt_q >= V_VIS_C);
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_iob_vga_timing.sv
// tb_iob_vga_timing
// -----------------
// Two instances share one clock: d0 uses the default 640x480 timing with a
// divide-by-4 pixel clock, d1 uses default horizontal timing, a divide-by-1
// pixel clock and a short 22-line frame so whole frames fit in the run.
// A closed-form raster model, driven only by the count of consecutive
// enabled clocks since the last restart, predicts every output each cycle.
module tb_iob_vga_timing;

  localparam int D0_DIV = 4;
  localparam int D1_DIV = 1;
  localparam int D1_VV  = 16;
  localparam int D1_VF  = 2;
  localparam int D1_VS  = 2;
  localparam int D1_VB  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, rst1, en1;
  logic [11:0] rgbIn0, rgbIn1;
  logic [9:0]  px0, py0, px1, py1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, vb0, fs0, hs1, vs1, vb1, fs1;

  int nEdge0 = 0;
  int nEdge1 = 0;
  int compared = 0;
  int mismatched = 0;
  bit chkOn = 1'b0;

  // Renderer stand-ins: colour is a pure function of the presented coordinate.
  assign rgbIn0 = {px0[3:0], py0[3:0], 4'hA};
  assign rgbIn1 = {px1[3:0], py1[3:0], px1[7:4]};

  iob_vga_timing #(.CLK_DIV(D0_DIV)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .rgb_in(rgbIn0),
    .pixel_x(px0), .pixel_y(py0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vga_hs(hs0), .vga_vs(vs0), .vblank(vb0), .frame_start(fs0)
  );

  iob_vga_timing #(.CLK_DIV(D1_DIV), .V_VIS(D1_VV), .V_FP(D1_VF),
                   .V_SYNC(D1_VS), .V_BP(D1_VB)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .rgb_in(rgbIn1),
    .pixel_x(px1), .pixel_y(py1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .vblank(vb1), .frame_start(fs1)
  );

  // Count consecutive clocks that saw rst released and en high.
  always @(posedge clk) begin
    nEdge0 <= (rst0 && en0) ? nEdge0 + 1 : 0;
    nEdge1 <= (rst1 && en1) ? nEdge1 + 1 : 0;
  end

  function automatic int pix(input int x, input int y, input bit alt);
    return ((x & 15) << 8) | ((y & 15) << 4) | (alt ? ((x >> 4) & 15) : 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int which, input logic enV, input logic rstV);
    if (which == 0) begin
      en0 = enV;
      rst0 = rstV;
    end else begin
      en1 = enV;
      rst1 = rstV;
    end
  endtask

  // Closed-form prediction: after n enabled clocks, t = n/div ticks have
  // happened; the counter sits at raster position t, the pins show position
  // t-1 (blank if no tick yet), and frame_start marks a tick landing on 0.
  task automatic checkModel(input string nm, input int n, input int div,
                            input int hv, input int hf, input int hsw, input int hb,
                            input int vv, input int vf, input int vsw, input int vb,
                            input bit alt, input logic [9:0] px, input logic [9:0] py,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic hs, input logic vs, input logic vbk, input logic fs);
    int hTot, vTot, tot, t, pos, ex, ey, prev, qx, qy, eRgb;
    logic eHs, eVs, eFs;
    hTot = hv + hf + hsw + hb;
    vTot = vv + vf + vsw + vb;
    tot  = hTot * vTot;
    t    = n / div;
    pos  = t % tot;
    ex   = pos % hTot;
    ey   = pos / hTot;
    eRgb = 0;
    eHs  = 1'b1;
    eVs  = 1'b1;
    if (t > 0) begin
      prev = (t - 1) % tot;
      qx   = prev % hTot;
      qy   = prev / hTot;
      if (qx < hv && qy < vv) eRgb = pix(qx, qy, alt);
      eHs = !(qx >= hv + hf && qx < hv + hf + hsw);
      eVs = !(qy >= vv + vf && qy < vv + vf + vsw);
    end
    eFs = (n > 0) && (n % div == 0) && (t % tot == 0);
    checkOutput({nm, ".pixel_x"}, px, ex);
    checkOutput({nm, ".pixel_y"}, py, ey);
    checkOutput({nm, ".rgb"}, {r, g, b}, eRgb);
    checkOutput({nm, ".vga_hs"}, hs, eHs);
    checkOutput({nm, ".vga_vs"}, vs, eVs);
    checkOutput({nm, ".vblank"}, vbk, ey >= vv);
    checkOutput({nm, ".frame_start"}, fs, eFs);
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      checkModel("d0", nEdge0, D0_DIV, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                 px0, py0, r0, g0, b0, hs0, vs0, vb0, fs0);
      checkModel("d1", nEdge1, D1_DIV, 640, 16, 96, 48, D1_VV, D1_VF, D1_VS, D1_VB, 1'b1,
                 px1, py1, r1, g1, b1, hs1, vs1, vb1, fs1);
    end
  end

  // Random disruption: kind 0 drops en, 1 pulses reset, 2 does both.
  task automatic disrupt(input int which);
    int kind, len;
    kind = int'($urandom_range(0, 2));
    len  = int'($urandom_range(1, 12));
    applyStimulus(which, kind == 1, kind == 0);
    repeat (len) @(negedge clk);
    applyStimulus(which, 1'b1, 1'b1);
  endtask

  task automatic runDut0();
    int cnt, run;
    cnt = 0;
    while (py0 !== 10'd1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("d0.line_clks", cnt, 3200);

    cnt = 0;
    while (px0 !== 10'd10 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    run = 0;
    while (px0 === 10'd10 && run < 20) begin
      run++;
      @(negedge clk);
    end
    checkOutput("d0.pixel_hold", run, 4);

    cnt = 0;
    while (!(px0 === 10'd5 && py0 === 10'd7) && cnt < 40000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("d0.found_5_7", (px0 === 10'd5 && py0 === 10'd7), 1);
    repeat (4) @(negedge clk);
    checkOutput("d0.r_at_5_7", r0, 5);
    checkOutput("d0.g_at_5_7", g0, 7);
    checkOutput("d0.b_at_5_7", b0, 'hA);
    checkOutput("d0.x_after_5_7", px0, 6);

    cnt = 0;
    while (px0 !== 10'd700 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    repeat (4) @(negedge clk);
    checkOutput("d0.rgb_blank_x700", {r0, g0, b0}, 0);
    checkOutput("d0.hs_low_x700", hs0, 0);

    repeat (4) begin
      repeat ($urandom_range(200, 1500)) @(negedge clk);
      disrupt(0);
    end
  endtask

  task automatic runDut1();
    int lows, cnt, len, vsLow, vbCnt, fsCnt;
    lows = 0;
    repeat (802) begin
      @(negedge clk);
      if (hs1 === 1'b0) lows++;
    end
    checkOutput("d1.hs_low_clks", lows, 96);

    cnt = 0;
    while (fs1 !== 1'b1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("d1.first_frame_start", fs1, 1);
    len = 0; vsLow = 0; vbCnt = 0; fsCnt = 0;
    do begin
      @(negedge clk);
      len++;
      if (vs1 === 1'b0) vsLow++;
      if (vb1 === 1'b1) vbCnt++;
      if (fs1 === 1'b1) fsCnt++;
    end while (fs1 !== 1'b1 && len < 20000);
    checkOutput("d1.frame_clks", len, 17600);
    checkOutput("d1.vs_low_clks", vsLow, 1600);
    checkOutput("d1.vblank_clks", vbCnt, 4800);
    checkOutput("d1.frame_start_count", fsCnt, 1);

    // Drop en mid-frame for 10 clocks.
    cnt = 0;
    while (!(px1 === 10'd300 && py1 === 10'd10) && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("d1.found_300_10_en", (px1 === 10'd300 && py1 === 10'd10), 1);
    applyStimulus(1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("d1.en_low_x", px1, 0);
    checkOutput("d1.en_low_y", py1, 0);
    checkOutput("d1.en_low_rgb", {r1, g1, b1}, 0);
    checkOutput("d1.en_low_hs", hs1, 1);
    applyStimulus(1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("d1.x_after_enable", px1, 1);
    checkOutput("d1.y_after_enable", py1, 0);

    // Same disruption with a single reset clock.
    cnt = 0;
    while (!(px1 === 10'd300 && py1 === 10'd10) && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("d1.found_300_10_rst", (px1 === 10'd300 && py1 === 10'd10), 1);
    applyStimulus(1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("d1.rst_x", px1, 0);
    checkOutput("d1.rst_y", py1, 0);
    checkOutput("d1.rst_rgb", {r1, g1, b1}, 0);
    applyStimulus(1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("d1.x_after_rst", px1, 1);

    repeat (8) begin
      repeat ($urandom_range(300, 2500)) @(negedge clk);
      disrupt(1);
    end
  endtask

  initial begin
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b0);
    @(posedge clk);
    chkOn = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset.d0.pixel_x", px0, 0);
    checkOutput("reset.d0.pixel_y", py0, 0);
    checkOutput("reset.d0.rgb", {r0, g0, b0}, 0);
    checkOutput("reset.d0.vga_hs", hs0, 1);
    checkOutput("reset.d0.vga_vs", vs0, 1);
    checkOutput("reset.d0.frame_start", fs0, 0);
    checkOutput("reset.d0.vblank", vb0, 0);
    checkOutput("reset.d1.rgb", {r1, g1, b1}, 0);
    checkOutput("reset.d1.vga_hs", hs1, 1);
    applyStimulus(0, 1'b1, 1'b1);
    applyStimulus(1, 1'b1, 1'b1);
    fork
      runDut0();
      runDut1();
    join
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
